// File: rtl/led_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_pkg
// Brief    : Shared mode encodings, bounce direction type and pattern helpers
//            for the LED pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
package led_pattern_pkg;

  // One-hot switch encodings; MODE_BOUNCE is only decoded when BOUNCE_EN is set
  localparam logic [3:0] MODE_LOAD   = 4'b0001;
  localparam logic [3:0] MODE_LEFT   = 4'b0010;
  localparam logic [3:0] MODE_RIGHT  = 4'b0100;
  localparam logic [3:0] MODE_TOGGLE = 4'b1000;
  localparam logic [3:0] MODE_BOUNCE = 4'b0110;

  // Widest LED bank the helpers below handle
  localparam int MAX_LED = 256;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Even bits set below bit n (...0101); callers slice the low n bits
  function automatic logic [MAX_LED-1:0] alt_pattern(input int n);
    logic [MAX_LED-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LED; i++) begin
      r[i] = ((i % 2) == 0) && (i < n);
    end
    return r;
  endfunction

  // True when exactly one bit is set; zero-extended LED vectors are passed in
  function automatic logic is_onehot(input logic [MAX_LED-1:0] v);
    return $onehot(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen_if
// Brief    : Switch/speed inputs and tick/LED outputs of the pattern generator.
//            master = board side driving switches, slave = generator.
// Revision : 1.0 - initial release
// ============================================================================
interface led_pattern_gen_if #(
  parameter int N_LED = 8
);
  logic [3:0]       sw;
  logic [1:0]       speed;
  logic             tick;
  logic [N_LED-1:0] led;

  modport master (
    output sw,
    output speed,
    input  tick,
    input  led
  );

  modport slave (
    input  sw,
    input  speed,
    output tick,
    output led
  );
endinterface
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider
// Brief    : Runtime-selectable prescaler. Period is (DIV >> speed) cycles;
//            tick is combinational from the count so a speed increase with the
//            count already past the new limit ticks at once without wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module tick_divider #(
  parameter int DIV = 24'hA00000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] speed,
  output logic            tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic [CW-1:0] lim_m1;

  // Limit computed at counter width; a power-of-two DIV truncates to 0 at
  // speed 0 and lim-1 wraps to all-ones, which is still the right terminal count
  always_comb begin
    lim    = CW'(DIV >> speed);
    lim_m1 = lim - CW'(1);
    tick   = (cnt >= lim_m1);
  end

  // Free-running count, cleared on the terminal cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Brief    : Switch-selected LED pattern generator: load, shift left/right,
//            alternating toggle and (with macro BOUNCE_EN) a bouncing dot.
//            Patterns step on a prescaled tick from tick_divider.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LED      = 8,
  parameter int DIV        = 24'hA00000,
  parameter int TOG_HALF   = 8,
  parameter int TOG_PERIOD = 18
) (
  input  wire logic         clk,
  input  wire logic         rst,
  led_pattern_gen_if.slave  bus
);
  localparam logic [MAX_LED-1:0] PAT_FULL = alt_pattern(N_LED);
  localparam logic [N_LED-1:0]   PAT_A    = PAT_FULL[N_LED-1:0];
  localparam logic [N_LED-1:0]   PAT_B    = ~PAT_A;
  localparam logic [N_LED-1:0]   LED_LSB  = N_LED'(1);
  localparam logic [N_LED-1:0]   LED_MSB  = LED_LSB << (N_LED - 1);
  localparam logic [7:0]         TOG_HALF_C = 8'(TOG_HALF);
  localparam logic [7:0]         TOG_LAST   = 8'(TOG_PERIOD - 1);

  logic               tick;
  logic [N_LED-1:0]   led;
  logic [N_LED-1:0]   led_next;
  logic [7:0]         tcnt;
  logic [7:0]         tcnt_next;
  logic [MAX_LED-1:0] led_ext;
  logic               led_onehot;
`ifdef BOUNCE_EN
  dir_t               dir;
  dir_t               dir_next;
`endif

  tick_divider #(
    .DIV (DIV)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .speed (bus.speed),
    .tick  (tick)
  );

  assign bus.tick = tick;
  assign bus.led  = led;

  // Zero-extend the LED bank so the package helper works for any width
  always_comb begin
    led_ext             = '0;
    led_ext[N_LED-1:0]  = led;
    led_onehot          = is_onehot(led_ext);
  end

  // Next-state decode: toggle counter always runs, LED update by switch mode
  always_comb begin
    led_next  = led;
    tcnt_next = tcnt;
`ifdef BOUNCE_EN
    dir_next  = dir;
`endif
    if (tick) begin
      tcnt_next = (tcnt == TOG_LAST) ? 8'd0 : tcnt + 8'd1;
    end
    case (bus.sw)
      MODE_LOAD: begin
        if (tick) led_next = LED_LSB;
      end
      MODE_LEFT: begin
        if (tick) led_next = led_onehot ? (led << 1) : LED_LSB;
      end
      MODE_RIGHT: begin
        if (tick) led_next = led_onehot ? (led >> 1) : LED_MSB;
      end
      MODE_TOGGLE: begin
        led_next = (tcnt < TOG_HALF_C) ? PAT_A : PAT_B;
      end
`ifdef BOUNCE_EN
      MODE_BOUNCE: begin
        if (tick) begin
          if (!led_onehot) begin
            led_next = LED_LSB;
            dir_next = DIR_LEFT;
          end else if ((dir == DIR_LEFT) && led[N_LED-1]) begin
            dir_next = DIR_RIGHT;
            led_next = led >> 1;
          end else if ((dir == DIR_RIGHT) && led[0]) begin
            dir_next = DIR_LEFT;
            led_next = led << 1;
          end else begin
            led_next = (dir == DIR_LEFT) ? (led << 1) : (led >> 1);
          end
        end
      end
`endif
      default: begin
        led_next = '0;
      end
    endcase
`ifdef BOUNCE_EN
    // Re-entering bounce always starts moving left
    if (bus.sw != MODE_BOUNCE) dir_next = DIR_LEFT;
`endif
  end

  // State registers; reset wins over a same-cycle tick
  always_ff @(posedge clk) begin
    if (rst) begin
      led  <= '0;
      tcnt <= '0;
`ifdef BOUNCE_EN
      dir  <= DIR_LEFT;
`endif
    end else begin
      led  <= led_next;
      tcnt <= tcnt_next;
`ifdef BOUNCE_EN
      dir  <= dir_next;
`endif
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_gen
// Brief    : Self-checking bench for led_pattern_gen (DIV=8, N_LED=8).
//            Expected LED values are queued per tick and checked one cycle
//            after each tick. Bounce checks follow macro BOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q [$];

  led_pattern_gen_if #(.N_LED(8)) bus ();

  led_pattern_gen #(
    .N_LED      (8),
    .DIV        (8),
    .TOG_HALF   (8),
    .TOG_PERIOD (18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Wait (bounded) until tick is high at a falling edge
  task automatic wait_tick(output int waited, output bit seen);
    waited = 0;
    seen   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  // For n ticks: wait for the tick, then compare led one cycle later
  task automatic run_ticks(input int n, input string name);
    int w;
    bit seen;
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      wait_tick(w, seen);
      if (!seen) begin
        total++; bad++;
        $display("FAIL %s step %0d: no tick within bound", name, k);
        exp_q.delete();
        return;
      end
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s step %0d: scoreboard empty, led=%h", name, k, bus.led);
      end else begin
        e = exp_q.pop_front();
        if (bus.led !== e) begin
          bad++;
          $display("FAIL %s step %0d: led=%h expected %h", name, k, bus.led, e);
        end
      end
    end
  endtask

  task automatic apply_reset(input logic [3:0] sw, input logic [1:0] speed);
    @(negedge clk);
    rst = 1'b1;
    bus.sw = sw;
    bus.speed = speed;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.sw = 4'b0000;
    bus.speed = 2'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.led !== 8'h00) begin bad++; $display("FAIL reset_led: led=%h expected 00", bus.led); end
    total++;
    if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick: tick=%b expected 0", bus.tick); end
    total++;
    if (dut.tcnt !== 8'd0) begin bad++; $display("FAIL reset_tcnt: tcnt=%0d expected 0", dut.tcnt); end
    total++;
    if (dut.u_div.cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt: cnt=%0d expected 0", dut.u_div.cnt); end
  endtask

  task automatic test_load();
    int w;
    bit seen;
    bus.sw = 4'b0001;
    rst = 1'b0;
    wait_tick(w, seen);
    total++;
    if (!seen || w != 7) begin
      bad++; $display("FAIL load_first_tick: waited=%0d seen=%b expected 7 cycles", w, seen);
    end
    @(negedge clk);
    total++;
    if (bus.led !== 8'h01) begin bad++; $display("FAIL load_first: led=%h expected 01", bus.led); end
    wait_tick(w, seen);
    total++;
    if (!seen || w != 7) begin
      bad++; $display("FAIL load_period: waited=%0d seen=%b expected 7 cycles", w, seen);
    end
    @(negedge clk);
    repeat (3) exp_q.push_back(8'h01);
    run_ticks(3, "load_hold");
  endtask

  task automatic test_shift_left();
    apply_reset(4'b0010, 2'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h01 << i);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    run_ticks(10, "shift_left");
  endtask

  task automatic test_shift_right();
    apply_reset(4'b0100, 2'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h80 >> i);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    run_ticks(10, "shift_right");
    // Just past a tick the count is 0; step to 5 then raise the speed
    repeat (5) @(negedge clk);
    total++;
    if (dut.u_div.cnt !== 3'd5) begin bad++; $display("FAIL speed_setup: cnt=%0d expected 5", dut.u_div.cnt); end
    bus.speed = 2'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.tick !== 1'b1 || dut.u_div.cnt !== 3'd0) begin
        bad++;
        $display("FAIL speed_fast cycle %0d: tick=%b cnt=%0d expected tick=1 cnt=0", i, bus.tick, dut.u_div.cnt);
      end
    end
    bus.speed = 2'd0;
  endtask

  task automatic test_toggle();
    int w;
    bit seen;
    apply_reset(4'b1000, 2'd0);
    for (int k = 0; k < 39; k++) exp_q.push_back(((k % 18) < 8) ? 8'h55 : 8'hAA);
    run_ticks(39, "toggle");
    // Reset on a tick cycle: tick must not advance tcnt or led
    wait_tick(w, seen);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (!seen || bus.led !== 8'h00 || dut.tcnt !== 8'd0) begin
      bad++;
      $display("FAIL toggle_rst: seen=%b led=%h tcnt=%0d expected led=00 tcnt=0", seen, bus.led, dut.tcnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_bounce();
`ifdef BOUNCE_EN
    apply_reset(4'b0110, 2'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h01 << i);
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h80 >> i);
    exp_q.push_back(8'h02);
    run_ticks(16, "bounce");
`else
    apply_reset(4'b0001, 2'd0);
    exp_q.push_back(8'h01);
    run_ticks(1, "bounce_preload");
    bus.sw = 4'b0110;
    @(negedge clk);
    total++;
    if (bus.led !== 8'h00) begin bad++; $display("FAIL bounce_invalid: led=%h expected 00", bus.led); end
`endif
  endtask

  task automatic test_invalid();
    logic [3:0] bad_sw [2];
    bad_sw[0] = 4'b0011;
    bad_sw[1] = 4'b0000;
    for (int j = 0; j < 2; j++) begin
      apply_reset(4'b0010, 2'd0);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h01 << i);
      run_ticks(5, "invalid_setup");
      bus.sw = bad_sw[j];
      @(negedge clk);
      total++;
      if (bus.led !== 8'h00 || bus.tick !== 1'b0) begin
        bad++;
        $display("FAIL invalid_sw %b: led=%h tick=%b expected led=00 tick=0", bad_sw[j], bus.led, bus.tick);
      end
    end
  endtask

  initial begin
    bus.sw = 4'b0000;
    bus.speed = 2'd0;
    test_reset();
    test_load();
    test_shift_left();
    test_shift_right();
    test_toggle();
    test_bounce();
    test_invalid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
